upcounter_hm: RTL and testbench
===============================

# upcounter_hm

Up-counting HH:MM stopwatch core, the counting-up counterpart of the team's countdown timer. It counts elapsed time from 00:00 toward a user-set target and stops there, or free-runs when the target is 00:00. It consumes the already-debounced, one-pulsed pushbutton strobes and the divided count tick. It drives four BCD digits to the existing decoder/display chain, plus the 16 LEDs.

## Interface
- HOUR_MAX, 23, highest hour value; hours wrap from HOUR_MAX to 0.
- MIN_MAX, 59, highest minute value; minutes wrap from MIN_MAX to 0.
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-high reset (driven from the debounced reset pushbutton, high = reset).
- tick  in  1  count enable, one-cycle pulse once per count period (from the divider).
- start_p  in  1  one-cycle start/stop strobe.
- pause_p  in  1  one-cycle pause/resume strobe.
- setting  in  1  level; high selects target-setting mode.
- set_min_p  in  1  one-cycle strobe; increments target minutes.
- set_hour_p  in  1  one-cycle strobe; increments target hours.
- one_m, ten_m, one_h, ten_h  out  4 each  BCD digits shown on the display.
- running  out  1  high in RUN.
- done  out  1  high in DONE.
- led  out  16  status LEDs.

## Operation
- State machine with states IDLE, RUN, HOLD and DONE.
- Registers:
  - Count: cnt_h 0..HOUR_MAX, cnt_m 0..MIN_MAX, each held as two BCD digits.
  - Target: tgt_h and tgt_m, same encoding.
- Reset: state IDLE, count 00:00, target 00:00, all outputs 0, led 16'h0000.
- IDLE:
  - setting=1: set_min_p increments tgt_m (59→00, no carry into hours); set_hour_p increments tgt_h (HOUR_MAX→00).
  - setting=1 and start_p: start_p is ignored.
  - setting=0 and start_p: go to RUN with count 00:00.
- RUN:
  - tick increments the count. Minutes wrap to 00 and carry into hours; 23:59 wraps to 00:00.
  - If the target is not 00:00 and the incremented count equals the target, go to DONE in that same edge.
  - pause_p → HOLD.
  - start_p → IDLE and clear the count.
- HOLD: tick is ignored; pause_p → RUN; start_p → IDLE and clear the count.
- DONE: count frozen at the target; tick and pause_p ignored; start_p → IDLE and clear the count.
- Set strobes are ignored outside IDLE. The target holds its value across runs.
- Digit mux: IDLE with setting=1 shows the target; every other case shows the count.
- led:
  - IDLE: led[13]=setting, all other bits 0.
  - RUN: led[15]=1.
  - HOLD: led[14]=1.
  - DONE: see Configuration.
- Simultaneous events:
  - start_p together with pause_p: start_p wins.
  - tick together with pause_p in RUN: the increment is applied, then HOLD.
  - tick together with start_p in RUN or HOLD: the clear wins (IDLE, count 00:00).
  - set_min_p together with set_hour_p: both fields increment.

## Timing
- All state, count and target updates are registered on the rising edge of clk.
- Digits, running, done and led reflect an event one cycle after the strobe or tick is sampled. They are combinational decodes of registers, with no additional pipeline stage.
- No handshake. Each strobe is assumed one cycle wide; a strobe held high acts on every cycle it is high.
- Asserting rst_n at any point, including mid-count or in DONE, immediately forces the reset values. The target is also cleared.

## Configuration
- UPCNT_BLINK_EN defined: in DONE, an internal blink bit toggles on every tick. led = all ones while blink=1 and all zeros while blink=0. Blink clears on entry to DONE and on reset.
- UPCNT_BLINK_EN undefined: in DONE, led = 16'hFFFF steadily. No blink register is synthesized.

## Test plan
- Reset, then setting=1, 3× set_min_p, 1× set_hour_p, setting=0 → digits 01:03 while setting is high; then 00:00 with led=0.
- Target 00:03, start_p, 3 ticks → count 00:01, 00:02, 00:03; done=1 and running=0 one cycle after the 3rd tick; further ticks leave 00:03.
- Target 00:00, preload via 59 ticks, then 1 tick → 00:59→01:00. Run to 23:59, 1 tick → 00:00 with running still 1.
- RUN at 00:05: pause_p, 4 ticks → stays 00:05, led[14]=1; pause_p, 1 tick → 00:06. Then start_p and pause_p in the same cycle → IDLE, 00:00.
- RUN at 00:02: tick and pause_p in the same cycle → 00:03 in HOLD. Then rst_n pulse → IDLE, target and count 00:00, led 0.
- DONE with UPCNT_BLINK_EN: led alternates 16'h0000/16'hFFFF on successive ticks. Without the macro: constant 16'hFFFF.

Source files
------------

// File: rtl/upcounter_hm_if.sv
// upcounter_hm_if
//   Strobe/level inputs and display/status outputs of the HH:MM up-counter.
//   clk and rst_n stay plain ports on the core.
//   Inputs : tick, start_p, pause_p, setting, set_min_p, set_hour_p
//   Outputs: one_m, ten_m, one_h, ten_h (BCD digits), running, done, led[15:0]
//   master = stimulus side, slave = the counter core.
interface upcounter_hm_if;
  logic        tick;
  logic        start_p;
  logic        pause_p;
  logic        setting;
  logic        set_min_p;
  logic        set_hour_p;
  logic [3:0]  one_m, ten_m, one_h, ten_h;
  logic        running;
  logic        done;
  logic [15:0] led;

  modport master (
    output tick, start_p, pause_p, setting, set_min_p, set_hour_p,
    input  one_m, ten_m, one_h, ten_h, running, done, led
  );
  modport slave (
    input  tick, start_p, pause_p, setting, set_min_p, set_hour_p,
    output one_m, ten_m, one_h, ten_h, running, done, led
  );
endinterface

// File: rtl/upcounter_hm.sv
// upcounter_hm
//   Up-counting HH:MM stopwatch. Counts from 00:00 on each tick while running,
//   stops at a user-set target, or free-runs (23:59 -> 00:00) when the target
//   is 00:00. Count and target are held as two BCD digits per field.
//   Ports:
//     clk   - system clock, rising edge
//     rst_n - asynchronous reset, ACTIVE HIGH despite its name
//     bus   - upcounter_hm_if.slave (strobes in, digits/running/done/led out)
//   Optional feature: define UPCNT_BLINK_EN to blink the LEDs in DONE
//   (toggle on every tick); otherwise DONE shows led = 16'hFFFF steadily.
module upcounter_hm #(
  parameter int HOUR_MAX = 23,
  parameter int MIN_MAX  = 59
) (
  input  logic          clk,
  input  logic          rst_n,
  upcounter_hm_if.slave bus
);

  localparam logic [7:0] HOUR_MAX_BCD = 8'((HOUR_MAX / 10) * 16 + HOUR_MAX % 10);
  localparam logic [7:0] MIN_MAX_BCD  = 8'((MIN_MAX / 10) * 16 + MIN_MAX % 10);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_cnt_h, r_cnt_m, r_tgt_h, r_tgt_m;
  logic [7:0] w_cnt_h_nxt, w_cnt_m_nxt, w_tgt_h_nxt, w_tgt_m_nxt;
  logic [7:0] w_inc_h, w_inc_m;
  logic       w_hit;
  logic [7:0] w_disp_h, w_disp_m;
`ifdef UPCNT_BLINK_EN
  logic       r_blink, w_blink_nxt;
`endif

  // Two-digit BCD increment wrapping from max to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max)         return 8'h00;
    if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Count value after one tick; hours advance only when minutes wrap.
  assign w_inc_m = bcd_inc(r_cnt_m, MIN_MAX_BCD);
  assign w_inc_h = (r_cnt_m == MIN_MAX_BCD) ? bcd_inc(r_cnt_h, HOUR_MAX_BCD) : r_cnt_h;
  // Target 00:00 means free-run, so it never matches.
  assign w_hit   = ({r_tgt_h, r_tgt_m} != 16'h0000) &&
                   ({w_inc_h, w_inc_m} == {r_tgt_h, r_tgt_m});

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state <= IDLE;
      r_cnt_h <= 8'h00;
      r_cnt_m <= 8'h00;
      r_tgt_h <= 8'h00;
      r_tgt_m <= 8'h00;
`ifdef UPCNT_BLINK_EN
      r_blink <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt_h <= w_cnt_h_nxt;
      r_cnt_m <= w_cnt_m_nxt;
      r_tgt_h <= w_tgt_h_nxt;
      r_tgt_m <= w_tgt_m_nxt;
`ifdef UPCNT_BLINK_EN
      r_blink <= w_blink_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_h_nxt = r_cnt_h;
    w_cnt_m_nxt = r_cnt_m;
    w_tgt_h_nxt = r_tgt_h;
    w_tgt_m_nxt = r_tgt_m;
`ifdef UPCNT_BLINK_EN
    w_blink_nxt = r_blink;
`endif
    case (r_state)
      IDLE: begin
        if (bus.setting) begin
          // Start is ignored while setting; minutes do not carry into hours.
          if (bus.set_min_p)  w_tgt_m_nxt = bcd_inc(r_tgt_m, MIN_MAX_BCD);
          if (bus.set_hour_p) w_tgt_h_nxt = bcd_inc(r_tgt_h, HOUR_MAX_BCD);
        end else if (bus.start_p) begin
          w_state_nxt = RUN;
          w_cnt_h_nxt = 8'h00;
          w_cnt_m_nxt = 8'h00;
        end
      end
      RUN: begin
        if (bus.start_p) begin
          w_state_nxt = IDLE;
          w_cnt_h_nxt = 8'h00;
          w_cnt_m_nxt = 8'h00;
        end else if (bus.tick) begin
          // Increment lands first; reaching the target beats a same-cycle pause.
          w_cnt_h_nxt = w_inc_h;
          w_cnt_m_nxt = w_inc_m;
          if (w_hit) begin
            w_state_nxt = DONE;
`ifdef UPCNT_BLINK_EN
            w_blink_nxt = 1'b0;
`endif
          end else if (bus.pause_p) begin
            w_state_nxt = HOLD;
          end
        end else if (bus.pause_p) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (bus.start_p) begin
          w_state_nxt = IDLE;
          w_cnt_h_nxt = 8'h00;
          w_cnt_m_nxt = 8'h00;
        end else if (bus.pause_p) begin
          w_state_nxt = RUN;
        end
      end
      DONE: begin
        if (bus.start_p) begin
          w_state_nxt = IDLE;
          w_cnt_h_nxt = 8'h00;
          w_cnt_m_nxt = 8'h00;
        end
`ifdef UPCNT_BLINK_EN
        else if (bus.tick) begin
          w_blink_nxt = ~r_blink;
        end
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Target is shown only while it is being edited.
  assign w_disp_h = (r_state == IDLE && bus.setting) ? r_tgt_h : r_cnt_h;
  assign w_disp_m = (r_state == IDLE && bus.setting) ? r_tgt_m : r_cnt_m;

  assign bus.ten_h   = w_disp_h[7:4];
  assign bus.one_h   = w_disp_h[3:0];
  assign bus.ten_m   = w_disp_m[7:4];
  assign bus.one_m   = w_disp_m[3:0];
  assign bus.running = (r_state == RUN);
  assign bus.done    = (r_state == DONE);

  always_comb begin
    bus.led = 16'h0000;
    case (r_state)
      IDLE: bus.led[13] = bus.setting;
      RUN:  bus.led[15] = 1'b1;
      HOLD: bus.led[14] = 1'b1;
`ifdef UPCNT_BLINK_EN
      DONE: bus.led = {16{r_blink}};
`else
      DONE: bus.led = 16'hFFFF;
`endif
      default: bus.led = 16'h0000;
    endcase
  end

endmodule

// File: tb/tb_upcounter_hm.sv
module tb_upcounter_hm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  upcounter_hm_if bus();
  upcounter_hm dut (.clk(clk), .rst_n(rst), .bus(bus.slave));

  int checks = 0;
  int errors = 0;
  int stepno = 0;

  // Reference model: elapsed time as plain minutes since 00:00.
  int m_st;      // 0 idle, 1 run, 2 hold, 3 done
  int m_cnt;
  int m_th, m_tm;
  bit m_blink;
  bit m_set;

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_th = 0; m_tm = 0; m_blink = 0;
  endtask

  task automatic model_step(input bit t, st, pa, se, sm, sh);
    int tgt;
    tgt = m_th * 60 + m_tm;
    case (m_st)
      0: if (se) begin
           if (sm) m_tm = (m_tm + 1) % 60;
           if (sh) m_th = (m_th + 1) % 24;
         end else if (st) begin
           m_st = 1; m_cnt = 0;
         end
      1: if (st) begin
           m_st = 0; m_cnt = 0;
         end else begin
           if (t) begin
             m_cnt = (m_cnt + 1) % 1440;
             if (tgt != 0 && m_cnt == tgt) begin m_st = 3; m_blink = 0; end
           end
           if (m_st == 1 && pa) m_st = 2;
         end
      2: if (st) begin m_st = 0; m_cnt = 0; end
         else if (pa) m_st = 1;
      default: if (st) begin m_st = 0; m_cnt = 0; end
               else if (t) m_blink = ~m_blink;
    endcase
  endtask

  function automatic logic [15:0] to_digits(input int v);
    int h, m;
    h = v / 60; m = v % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s#%0d observed=%h expected=%h", tag, stepno, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [15:0] e_dig, e_led;
    e_dig = (m_st == 0 && m_set) ? to_digits(m_th * 60 + m_tm) : to_digits(m_cnt);
    case (m_st)
      0: e_led = m_set ? 16'h2000 : 16'h0000;
      1: e_led = 16'h8000;
      2: e_led = 16'h4000;
`ifdef UPCNT_BLINK_EN
      default: e_led = m_blink ? 16'hFFFF : 16'h0000;
`else
      default: e_led = 16'hFFFF;
`endif
    endcase
    chk({tag, "_dig"}, {bus.ten_h, bus.one_h, bus.ten_m, bus.one_m}, e_dig);
    chk({tag, "_run"}, {15'd0, bus.running}, {15'd0, m_st == 1});
    chk({tag, "_done"}, {15'd0, bus.done}, {15'd0, m_st == 3});
    chk({tag, "_led"}, bus.led, e_led);
  endtask

  function automatic logic [15:0] dig();
    return {bus.ten_h, bus.one_h, bus.ten_m, bus.one_m};
  endfunction

  // One clock: drive inputs, step the model on the edge, check #1 later.
  task automatic cyc(input string tag, input bit t, st, pa, se, sm, sh);
    bus.tick = t; bus.start_p = st; bus.pause_p = pa;
    bus.setting = se; bus.set_min_p = sm; bus.set_hour_p = sh;
    m_set = se;
    @(posedge clk);
    model_step(t, st, pa, se, sm, sh);
    #1;
    stepno++;
    check_model(tag);
  endtask

  task automatic async_reset(input string tag);
    bus.tick = 0; bus.start_p = 0; bus.pause_p = 0;
    bus.setting = 0; bus.set_min_p = 0; bus.set_hour_p = 0;
    m_set = 0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk({tag, "_dig"}, dig(), 16'h0000);
    chk({tag, "_led"}, bus.led, 16'h0000);
    chk({tag, "_flags"}, {14'd0, bus.running, bus.done}, 16'h0000);
    @(negedge clk) rst = 1'b0;
  endtask

  initial begin
    model_reset();
    m_set = 0;
    bus.tick = 0; bus.start_p = 0; bus.pause_p = 0;
    bus.setting = 0; bus.set_min_p = 0; bus.set_hour_p = 0;
    repeat (3) @(posedge clk);
    #1;
    check_model("reset");
    chk("reset_dig", dig(), 16'h0000);
    @(negedge clk) rst = 1'b0;

    // Target entry: 3 minutes, 1 hour -> 01:03 while setting.
    cyc("set", 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc("setm", 0, 0, 0, 1, 1, 0);
    cyc("seth", 0, 0, 0, 1, 0, 1);
    chk("tgt_0103", dig(), 16'h0103);
    chk("led13", bus.led, 16'h2000);
    cyc("unset", 0, 0, 0, 0, 0, 0);
    chk("unset_dig", dig(), 16'h0000);
    // Start while setting is ignored; set strobes together bump both fields.
    cyc("set_start", 0, 1, 0, 1, 1, 1);
    chk("set_both", dig(), 16'h0204);
    // Bring hours back to 00 (02 + 22 wraps), minutes 04 -> keep 03: wrap 59 steps.
    for (int i = 0; i < 22; i++) cyc("seth_wrap", 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 59; i++) cyc("setm_wrap", 0, 0, 0, 1, 1, 0);
    chk("tgt_0003", dig(), 16'h0003);

    // Target 00:03: run to DONE, further ticks frozen.
    cyc("start", 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("run3", 1, 0, 0, 0, 0, 0);
    chk("done_flag", {15'd0, bus.done}, 16'd1);
    chk("done_dig", dig(), 16'h0003);
    for (int i = 0; i < 4; i++) cyc("done_tick", 1, 0, (i == 1), 0, 0, 0);
    chk("done_frozen", dig(), 16'h0003);
    cyc("done_set_ign", 0, 0, 0, 1, 1, 1);
    cyc("done_stop", 0, 1, 0, 0, 0, 0);

    // Target back to 00:00 (03 + 57 wraps) for free-run.
    for (int i = 0; i < 57; i++) cyc("setm_z", 0, 0, 0, 1, 1, 0);
    cyc("unset2", 0, 0, 0, 0, 0, 0);
    cyc("start_fr", 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 60; i++) cyc("fr", 1, 0, 0, 0, 0, 0);
    chk("fr_0100", dig(), 16'h0100);
    for (int i = 0; i < 1379; i++) cyc("fr", 1, 0, 0, 0, 0, 0);
    chk("fr_2359", dig(), 16'h2359);
    cyc("fr_wrap", 1, 0, 0, 0, 0, 0);
    chk("fr_wrap_dig", dig(), 16'h0000);
    chk("fr_wrap_run", {15'd0, bus.running}, 16'd1);

    // Pause/resume at 00:05, then start+pause together.
    cyc("restart", 0, 1, 0, 0, 0, 0);
    cyc("restart2", 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc("to5", 1, 0, 0, 0, 0, 0);
    cyc("pause", 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc("hold", 1, 0, 0, 0, 0, 0);
    chk("hold_dig", dig(), 16'h0005);
    chk("hold_led", bus.led, 16'h4000);
    cyc("resume", 0, 0, 1, 0, 0, 0);
    cyc("resume_t", 1, 0, 0, 0, 0, 0);
    chk("resume_dig", dig(), 16'h0006);
    cyc("st_pa", 0, 1, 1, 0, 0, 0);
    chk("st_pa_dig", dig(), 16'h0000);
    chk("st_pa_run", {15'd0, bus.running}, 16'd0);

    // Tick + pause at 00:02 -> 00:03 in HOLD, then async reset.
    cyc("start3", 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) cyc("to2", 1, 0, 0, 0, 0, 0);
    cyc("tick_pa", 1, 0, 1, 0, 0, 0);
    chk("tick_pa_dig", dig(), 16'h0003);
    chk("tick_pa_led", bus.led, 16'h4000);
    cyc("hold_tick_st", 1, 1, 0, 0, 0, 0);
    cyc("start4", 0, 1, 0, 0, 0, 0);
    cyc("run4", 1, 0, 0, 0, 0, 0);
    async_reset("arst");
    cyc("post_rst", 0, 0, 0, 1, 0, 0);
    chk("post_rst_tgt", dig(), 16'h0000);

    // DONE LED behaviour with target 00:02.
    for (int i = 0; i < 2; i++) cyc("setm2", 0, 0, 0, 1, 1, 0);
    cyc("start5", 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) cyc("to_done", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc("blink", 1, 0, 0, 0, 0, 0);
`ifdef UPCNT_BLINK_EN
      chk("blink_led", bus.led, (i % 2 == 0) ? 16'hFFFF : 16'h0000);
`else
      chk("steady_led", bus.led, 16'hFFFF);
`endif
    end
    cyc("done_idle", 0, 0, 0, 0, 0, 0);
    cyc("done_stop2", 0, 1, 0, 0, 0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cyc("rnd", 1'($urandom_range(0, 1)), ($urandom_range(0, 24) == 0),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
      if (i == 300) async_reset("rnd_arst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
